// File: rtl/seven_seg_scan_driver.sv
// Multiplexed seven-segment scanner: one digit per 16*STEP-cycle dwell, slot 0 is a dark
// ghosting guard, slots 1..brightness light the anode; per-digit dp/blank/blink, selectable polarity.
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS     = 6,
  parameter int CLK_HZ         = 100_000_000,
  parameter int DIGIT_HZ       = 1000,
  parameter int BLINK_HZ       = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  localparam int IDX_W = $clog2((NUM_DIGITS > 2) ? NUM_DIGITS : 2)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic [3:0]              brightness,
  output logic [6:0]              seg,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [IDX_W-1:0]        digit_idx
);

  localparam int DWELL   = (DIGIT_HZ > 0) ? CLK_HZ / DIGIT_HZ : 0;
  localparam int STEP    = DWELL / 16;
  localparam int HALF    = (BLINK_HZ > 0) ? CLK_HZ / (2 * BLINK_HZ) : 0;
  localparam int STEP_W  = $clog2((STEP > 2) ? STEP : 2);
  localparam int BLINK_W = $clog2((HALF > 2) ? HALF : 2);

  localparam logic [STEP_W-1:0]     STEP_LAST  = STEP_W'(STEP - 1);
  localparam logic [BLINK_W-1:0]    BLINK_LAST = BLINK_W'(HALF - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF     = AN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  localparam logic [6:0]            SEG_OFF    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF     = SEG_ACTIVE_LOW;

  if (NUM_DIGITS < 1 || NUM_DIGITS > 16 || DIGIT_HZ < 1 || BLINK_HZ < 1 || STEP < 1 || HALF < 1)
  begin : g_bad_params
    $error("seven_seg_scan_driver: illegal parameter set");
  end

  // Active-low segment literal, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] decode(input logic [3:0] c);
    case (c)
      4'h0:    decode = 7'b1000000;
      4'h1:    decode = 7'b1111001;
      4'h2:    decode = 7'b0100100;
      4'h3:    decode = 7'b0110000;
      4'h4:    decode = 7'b0011001;
      4'h5:    decode = 7'b0010010;
      4'h6:    decode = 7'b0000010;
      4'h7:    decode = 7'b1111000;
      4'h8:    decode = 7'b0000000;
      4'h9:    decode = 7'b0011000;
      4'hA:    decode = 7'b0001000;
      4'hB:    decode = 7'b0000011;
      4'hC:    decode = 7'b1000110;
      4'hD:    decode = 7'b0100001;
      4'hE:    decode = 7'b0000110;
      default: decode = 7'b0001110;
    endcase
  endfunction

  logic [STEP_W-1:0]     step_q, step_d;
  logic [3:0]            slot_q, slot_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [BLINK_W-1:0]    blink_cnt_q, blink_cnt_d;
  logic                  blink_on_q, blink_on_d;
  logic [3:0]            code_q, code_d;
  logic                  dp_q, dp_d;
  logic                  blank_q, blank_d;
  logic                  blink_q, blink_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_out_q, dp_out_d;
  logic [IDX_W-1:0]      didx_q, didx_d;

  logic [3:0]            code_sel;
  logic                  dp_sel, blank_sel, blink_sel, capture, lit;
  logic [NUM_DIGITS-1:0] onehot;

  always_ff @(posedge clk) begin
    if (rst) begin
      step_q      <= '0;
      slot_q      <= '0;
      idx_q       <= '0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      code_q      <= '0;
      dp_q        <= 1'b0;
      blank_q     <= 1'b1;
      blink_q     <= 1'b0;
      an_q        <= AN_OFF;
      seg_q       <= SEG_OFF;
      dp_out_q    <= DP_OFF;
      didx_q      <= '0;
    end else begin
      step_q      <= step_d;
      slot_q      <= slot_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      code_q      <= code_d;
      dp_q        <= dp_d;
      blank_q     <= blank_d;
      blink_q     <= blink_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_out_q    <= dp_out_d;
      didx_q      <= didx_d;
    end
  end

  always_comb begin
    step_d      = step_q + 1'b1;
    slot_d      = slot_q;
    idx_d       = idx_q;
    if (step_q == STEP_LAST) begin
      step_d = '0;
      slot_d = slot_q + 4'd1;
      if (slot_q == 4'hF) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    blink_cnt_d = blink_cnt_q + 1'b1;
    blink_on_d  = blink_on_q;
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      blink_on_d  = ~blink_on_q;
    end
  end

  // Per-digit attributes are sampled once at the start of the dwell and held until the next one.
  always_comb begin
    code_sel  = '0;
    dp_sel    = 1'b0;
    blank_sel = 1'b0;
    blink_sel = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        code_sel  = digits[4*i +: 4];
        dp_sel    = dp[i];
        blank_sel = blank_mask[i];
        blink_sel = blink_mask[i];
      end
    end
    capture = (step_q == '0) && (slot_q == 4'd0);
    code_d  = capture ? code_sel  : code_q;
    dp_d    = capture ? dp_sel    : dp_q;
    blank_d = capture ? blank_sel : blank_q;
    blink_d = capture ? blink_sel : blink_q;
  end

  always_comb begin
    lit      = (slot_q != 4'd0) && (slot_q <= brightness) && !blank_d && !(blink_d && !blink_on_q);
    onehot   = lit ? (NUM_DIGITS'(1) << idx_q) : '0;
    an_d     = AN_ACTIVE_LOW ? ~onehot : onehot;
    seg_d    = SEG_ACTIVE_LOW ? decode(code_d) : ~decode(code_d);
    dp_out_d = SEG_ACTIVE_LOW ? ~dp_d : dp_d;
    didx_d   = idx_q;
  end

  assign seg       = seg_q;
  assign dp_out    = dp_out_q;
  assign an        = an_q;
  assign digit_idx = didx_q;

endmodule
